// File: rtl/nibble_serial_comparator.sv
// Serial MSB-first unsigned comparator: one 4-bit nibble per clock, valid/ready in and out.
// Optional early exit on first differing nibble: define NIBBLE_CMP_EARLY_EXIT_EN.

module nibble_cmp_stage (
  input  logic       lt_in,
  input  logic       eq_in,
  input  logic       gt_in,
  input  logic [3:0] na,
  input  logic [3:0] nb,
  output logic       lt_o,
  output logic       eq_o,
  output logic       gt_o
);

  // Once a more significant nibble has decided the result, lower nibbles cannot change it.
  always_comb begin
    lt_o = lt_in;
    eq_o = eq_in;
    gt_o = gt_in;
    if (eq_in) begin
      lt_o = (na < nb);
      eq_o = (na == nb);
      gt_o = (na > nb);
    end
  end

endmodule

module nibble_serial_comparator #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt_out,
  output logic             eq_out,
  output logic             gt_out
);

  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   sa, sb;
  logic [CNT_W-1:0]   cnt;
  logic               casc_lt, casc_eq, casc_gt;
  logic               stg_lt, stg_eq, stg_gt;
  logic               accept, finish, release_res;

  nibble_cmp_stage u_stage (
    .lt_in (casc_lt),
    .eq_in (casc_eq),
    .gt_in (casc_gt),
    .na    (sa[WIDTH-1 -: 4]),
    .nb    (sb[WIDTH-1 -: 4]),
    .lt_o  (stg_lt),
    .eq_o  (stg_eq),
    .gt_o  (stg_gt)
  );

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    finish      = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          next_state = CMP;
        end
      end
      CMP: begin
`ifdef NIBBLE_CMP_EARLY_EXIT_EN
        finish = (cnt == '0) || (casc_eq && !stg_eq);
`else
        finish = (cnt == '0);
`endif
        if (finish) next_state = DONE;
      end
      DONE: begin
        if (out_ready) begin
          release_res = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Operand shifters, nibble counter and cascade; the top nibble is always the one under test.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      casc_lt <= 1'b0;
      casc_eq <= 1'b0;
      casc_gt <= 1'b0;
    end else if (accept) begin
      sa      <= a;
      sb      <= b;
      cnt     <= CNT_W'(NIBBLES - 1);
      casc_lt <= 1'b0;
      casc_eq <= 1'b1;
      casc_gt <= 1'b0;
    end else if (state == CMP) begin
      sa      <= sa << 4;
      sb      <= sb << 4;
      cnt     <= cnt - 1'b1;
      casc_lt <= stg_lt;
      casc_eq <= stg_eq;
      casc_gt <= stg_gt;
    end
  end

  // Result flags are loaded from the freshly updated cascade and held until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst || release_res) begin
      lt_out <= 1'b0;
      eq_out <= 1'b0;
      gt_out <= 1'b0;
    end else if (finish) begin
      lt_out <= stg_lt;
      eq_out <= stg_eq;
      gt_out <= stg_gt;
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> $onehot({lt_out, eq_out, gt_out}));

endmodule

// File: tb/tb_nibble_serial_comparator.sv
// Directed self-checking bench for nibble_serial_comparator at WIDTH=16.
// Expected latencies follow the NIBBLE_CMP_EARLY_EXIT_EN setting of the build.

module tb_nibble_serial_comparator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        lt_out, eq_out, gt_out;

  int checks = 0;
  int errors = 0;

  nibble_serial_comparator #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt_out    (lt_out),
    .eq_out    (eq_out),
    .gt_out    (gt_out)
  );

  always #5 clk = ~clk;

`ifdef NIBBLE_CMP_EARLY_EXIT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  // Presents a pair for one edge; returns at the negedge after the acceptance edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid is seen; -1 if it never appears.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if ({lt_out, eq_out, gt_out} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {lt_out, eq_out, gt_out}); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready_during_rst: got %b expected 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_after: got %b expected 1", in_ready); end
  endtask

  task automatic test_equal();
    int lat;
    send(16'h1234, 16'h1234);
    wait_result(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL equal_latency: got %0d expected 4", lat); end
    checks++;
    if ({lt_out, eq_out, gt_out} !== 3'b010) begin errors++; $display("[TB] FAIL equal_flags: got %b expected 010", {lt_out, eq_out, gt_out}); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL equal_in_ready_done: got %b expected 0", in_ready); end
    take_result();
    checks++;
    if ({out_valid, lt_out, eq_out, gt_out} !== 4'b0000) begin errors++; $display("[TB] FAIL equal_release: got %b expected 0000", {out_valid, lt_out, eq_out, gt_out}); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL equal_idle_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_gt_first();
    int lat;
    int exp_lat;
    exp_lat = EARLY ? 1 : 4;
    send(16'h9000, 16'h8FFF);
    wait_result(lat);
    checks++;
    if (lat !== exp_lat) begin errors++; $display("[TB] FAIL gt_first_latency: got %0d expected %0d", lat, exp_lat); end
    checks++;
    if ({lt_out, eq_out, gt_out} !== 3'b001) begin errors++; $display("[TB] FAIL gt_first_flags: got %b expected 001", {lt_out, eq_out, gt_out}); end
    take_result();
  endtask

  task automatic test_lt_last();
    int lat;
    send(16'h00F0, 16'h00F1);
    wait_result(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL lt_last_latency: got %0d expected 4", lat); end
    checks++;
    if ({lt_out, eq_out, gt_out} !== 3'b100) begin errors++; $display("[TB] FAIL lt_last_flags: got %b expected 100", {lt_out, eq_out, gt_out}); end
    take_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    int exp_lat;
    int bad;
    exp_lat = EARLY ? 1 : 4;
    send(16'h0001, 16'h0002);
    wait_result(lat);
    checks++;
    if (lat < 0) begin errors++; $display("[TB] FAIL bp_first_result: got %0d expected >0", lat); end
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'h0000;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({out_valid, in_ready, lt_out, eq_out, gt_out} !== 5'b10100) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d bad cycles expected 0", bad); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL bp_idle: got %b expected 01", {out_valid, in_ready}); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_accepted: got in_ready %b expected 0", in_ready); end
    wait_result(lat);
    checks++;
    if (lat !== exp_lat) begin errors++; $display("[TB] FAIL bp_second_latency: got %0d expected %0d", lat, exp_lat); end
    checks++;
    if ({lt_out, eq_out, gt_out} !== 3'b001) begin errors++; $display("[TB] FAIL bp_second_flags: got %b expected 001", {lt_out, eq_out, gt_out}); end
    take_result();
  endtask

  task automatic test_reset_mid();
    int stale;
    send(16'h1234, 16'h1235);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, lt_out, eq_out, gt_out, in_ready} !== 5'b00000) begin errors++; $display("[TB] FAIL mid_reset_state: got %b expected 00000", {out_valid, lt_out, eq_out, gt_out, in_ready}); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_ready: got %b expected 1", in_ready); end
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stale++;
    end
    checks++;
    if (stale !== 0) begin errors++; $display("[TB] FAIL mid_reset_stale: got %0d bad cycles expected 0", stale); end
  endtask

  task automatic test_operand_hold();
    int lat;
    send(16'h0005, 16'h0003);
    a = 16'h0000;
    b = 16'hFFFF;
    in_valid = 1'b1;
    wait_result(lat);
    in_valid = 1'b0;
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL hold_latency: got %0d expected 4", lat); end
    checks++;
    if ({lt_out, eq_out, gt_out} !== 3'b001) begin errors++; $display("[TB] FAIL hold_flags: got %b expected 001", {lt_out, eq_out, gt_out}); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_equal();
    test_gt_first();
    test_lt_last();
    test_back_to_back();
    test_reset_mid();
    test_operand_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_comparator.md
Name: nibble_serial_comparator

Overview:
- Compares two WIDTH-bit unsigned operands by walking 4-bit nibbles MSB-first, one nibble per clock.
- Carries a registered lt/eq/gt cascade state between nibbles, using the same cascade semantics as the team's four-bit comparator stage.
- Sits upstream of result consumers. Accepts operand pairs on a valid/ready input handshake and presents a held three-flag result on a valid/ready output handshake.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived nibble count; do not override.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result flags are valid.
- out_ready  input  1  consumer accepts the result.
- lt_out  output  1  a < b.
- eq_out  output  1  a == b.
- gt_out  output  1  a > b.

Behaviour:
- Reset: rst sampled high at an edge forces state IDLE and clears all internal state.
  - Outputs after reset: out_valid=0, lt_out=0, eq_out=0, gt_out=0.
  - in_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
  - rst has priority over every other event, including mid-compare and while holding a result.
- States: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at an edge (acceptance edge E0): latch a and b into shift registers, set cascade to (lt=0, eq=1, gt=0), load the nibble counter with NIBBLES-1, go to CMP.
  - Later changes on a, b, or in_valid have no effect on the operation in progress.
- CMP:
  - in_ready=0, out_valid=0.
  - On each edge, evaluate the top nibbles na, nb:
    - If cascade eq=1: cascade becomes (na<nb, na==nb, na>nb).
    - Otherwise the cascade holds.
  - Then shift both registers left by 4 and decrement the counter.
  - The final nibble (counter==0) is evaluated on edge E_NIBBLES. That edge loads lt_out/eq_out/gt_out from the updated cascade, sets out_valid=1, and goes to DONE.
- DONE:
  - out_valid=1; flags held stable; in_ready=0.
  - On out_ready=1 at an edge: out_valid=0, flags cleared to 0, go to IDLE.
  - No acceptance in the same edge. Minimum initiation interval is NIBBLES+2 cycles.
- Invariant: when out_valid=1, exactly one of lt_out/eq_out/gt_out is 1.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Arithmetic: unsigned only; no sign handling. The counter is clog2(NIBBLES) bits, minimum 1.

Optional Feature:
- Macro: NIBBLE_CMP_EARLY_EXIT_EN
- Defined: in CMP, the first edge at which cascade eq transitions 1→0 loads the flags, sets out_valid=1 and goes to DONE immediately. Result latency is the index of the first differing nibble, counted from MSB starting at 1. Equal operands still take NIBBLES edges.
- Undefined: fixed latency; out_valid always rises on edge E_NIBBLES regardless of data.
- Flag values are identical in both builds; only latency differs.

Test Plan (WIDTH=16):
1. a=0x1234, b=0x1234 → out_valid rises at E4 after acceptance; eq_out=1, lt_out=0, gt_out=0; same in both builds.
2. a=0x9000, b=0x8FFF → gt_out=1. With EARLY_EXIT_EN, out_valid at E1; without it, out_valid at E4.
3. a=0x00F0, b=0x00F1 → lt_out=1 at E4 in both builds, since the difference is in the last nibble.
4. Backpressure: result pending with out_ready=0 for 5 cycles, new in_valid=1 with a=0xFFFF, b=0 → flags and out_valid stable, in_ready=0, new pair not accepted. out_ready=1 → IDLE next cycle, then the pair is accepted and gives gt_out=1.
5. rst=1 for one edge at E2 of a 0x1234/0x1235 compare → next cycle state IDLE, out_valid=0, all flags 0, in_ready=1 after rst drops. No stale result appears later.
6. Operand hold: after acceptance of a=0x0005, b=0x0003, drive a=0, b=0xFFFF → result still gt_out=1.
